// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and decodes every datapath strobe from the state.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_SLTI  = 6'b001010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDI   = 4'd10,
    S_IMMWB  = 4'd11,
    S_SLTI   = 4'd12
  } state_t;

  state_t     cur_state, next_state;

  logic       pc_write, pc_write_cond;
  logic       iord_raw, mem_read_raw, mem_write_raw, ir_write_raw;
  logic       mem_to_reg_raw, reg_dst_raw, reg_write_raw, alu_src_a_raw;
  logic [1:0] alu_src_b_raw, alu_op_raw, pc_src_raw;
  logic       instr_done_raw, illegal_op_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= S_FETCH;
    else     cur_state <= next_state;
  end

  always_comb begin
    next_state     = S_FETCH;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    iord_raw       = 1'b0;
    mem_read_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    mem_to_reg_raw = 1'b0;
    reg_dst_raw    = 1'b0;
    reg_write_raw  = 1'b0;
    alu_src_a_raw  = 1'b0;
    alu_src_b_raw  = 2'b00;
    alu_op_raw     = 2'b00;
    pc_src_raw     = 2'b00;
    instr_done_raw = 1'b0;
    illegal_op_raw = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read_raw  = 1'b1;
        ir_write_raw  = 1'b1;
        pc_write      = 1'b1;
        alu_src_b_raw = 2'b01;
        next_state    = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target in ALUOut while the opcode is decoded.
        alu_src_b_raw = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEMADR;
        else if (opcode == OP_RTYPE)            next_state = S_EXEC;
        else if (opcode == OP_BEQ)              next_state = S_BRANCH;
        else if (opcode == OP_J)                next_state = S_JUMP;
        else if (opcode == OP_ADDI)             next_state = S_ADDI;
        else if (opcode == OP_SLTI)             next_state = S_SLTI;
        else begin
          next_state     = S_FETCH;
          illegal_op_raw = 1'b1;
          instr_done_raw = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = 2'b10;
        next_state    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        iord_raw     = 1'b1;
        next_state   = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg_raw = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw  = 1'b1;
        iord_raw       = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_raw = 1'b1;
        alu_op_raw    = 2'b10;
        next_state    = S_RWB;
      end
      S_RWB: begin
        reg_write_raw  = 1'b1;
        reg_dst_raw    = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_raw  = 1'b1;
        alu_op_raw     = 2'b01;
        pc_src_raw     = 2'b01;
        pc_write_cond  = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_JUMP: begin
        pc_src_raw     = 2'b10;
        pc_write       = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_ADDI: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = 2'b10;
        next_state    = S_IMMWB;
      end
      S_SLTI: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = 2'b10;
        alu_op_raw    = 2'b11;
        next_state    = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Reset masks every output, so the FETCH decode of state 0 cannot fire a write during rst.
  assign pc_en      = ~rst & (pc_write | (pc_write_cond & zero));
  assign iord       = ~rst & iord_raw;
  assign mem_read   = ~rst & mem_read_raw;
  assign mem_write  = ~rst & mem_write_raw;
  assign ir_write   = ~rst & ir_write_raw;
  assign mem_to_reg = ~rst & mem_to_reg_raw;
  assign reg_dst    = ~rst & reg_dst_raw;
  assign reg_write  = ~rst & reg_write_raw;
  assign alu_src_a  = ~rst & alu_src_a_raw;
  assign alu_src_b  = rst ? 2'b00 : alu_src_b_raw;
  assign alu_op     = rst ? 2'b00 : alu_op_raw;
  assign pc_src     = rst ? 2'b00 : pc_src_raw;
  assign instr_done = ~rst & instr_done_raw;
  assign illegal_op = ~rst & illegal_op_raw;
  assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push expected
// per-cycle output bundles; a negedge monitor pops and compares them.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];
  string       name_q[$];

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Bundle order: pc_en iord mem_read mem_write ir_write mem_to_reg reg_dst reg_write
  //               alu_src_a alu_src_b alu_op pc_src instr_done illegal_op state
  function automatic logic [20:0] row(input logic [3:0] st, input logic pce, input logic io,
      input logic mr, input logic mw, input logic irw, input logic m2r, input logic rd,
      input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
      input logic [1:0] ps, input logic dn, input logic il);
    return {pce, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, dn, il, st};
  endfunction

  wire [20:0] actual = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                        reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done,
                        illegal_op, state};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [20:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (actual !== e) begin
        errors++;
        $display("FAIL %s got=%b required=%b", n, actual, e);
      end
    end
  end

  task automatic cyc(input logic [20:0] r, input string n);
    exp_q.push_back(r);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  //                       st    pe io mr mw ir mr rd rw a  b      op     ps     d  i
  task automatic fetch(input string n);
    cyc(row(4'd0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0), {n, "_fetch"});
  endtask
  task automatic decode(input string n);
    cyc(row(4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0), {n, "_decode"});
  endtask
  task automatic rst_row(input string n);
    cyc(row(4'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), n);
  endtask
  task automatic memadr(input string n);
    cyc(row(4'd2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0), {n, "_memadr"});
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    rst_row("reset0");
    rst_row("reset1");
    rst = 1'b0;

    // lw: 0,1,2,3,4
    opcode = 6'b100011;
    fetch("lw"); decode("lw"); memadr("lw");
    cyc(row(4'd3,  0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "lw_memrd");
    cyc(row(4'd4,  0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0), "lw_memwb");

    // R-type: 0,1,6,7
    opcode = 6'b000000;
    fetch("r"); decode("r");
    cyc(row(4'd6,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0), "r_exec");
    cyc(row(4'd7,  0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0), "r_rwb");

    // sw: 0,1,2,5 ; opcode wiggles in S5 are ignored
    opcode = 6'b101011;
    fetch("sw"); decode("sw"); memadr("sw");
    opcode = 6'b111111;
    cyc(row(4'd5,  0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0), "sw_memwr");

    // beq taken and not taken
    opcode = 6'b000100;
    zero   = 1'b1;
    fetch("beq_t"); decode("beq_t");
    cyc(row(4'd8,  1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0), "beq_t_branch");
    zero   = 1'b0;
    fetch("beq_n"); decode("beq_n");
    cyc(row(4'd8,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0), "beq_n_branch");

    // addi: 0,1,10,11
    opcode = 6'b001000;
    fetch("addi"); decode("addi");
    cyc(row(4'd10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0), "addi_exec");
    cyc(row(4'd11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0), "addi_immwb");

    // slti: 0,1,12,11
    opcode = 6'b001010;
    fetch("slti"); decode("slti");
    cyc(row(4'd12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 2'b00, 0, 0), "slti_exec");
    cyc(row(4'd11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0), "slti_immwb");

    // j: 0,1,9
    opcode = 6'b000010;
    fetch("j"); decode("j");
    cyc(row(4'd9,  1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0), "j_jump");

    // illegal: 0,1 with pulses, then back to FETCH
    opcode = 6'b111111;
    fetch("ill");
    cyc(row(4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 1), "ill_decode");

    // lw interrupted by reset on entry to S3
    opcode = 6'b100011;
    fetch("lwrst"); decode("lwrst"); memadr("lwrst");
    rst = 1'b1;
    rst_row("lwrst_mid0");
    rst_row("lwrst_mid1");
    rst = 1'b0;

    // first instruction after release starts with FETCH
    opcode = 6'b000010;
    fetch("post"); decode("post");
    cyc(row(4'd9,  1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0), "post_jump");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
